// File: rtl/gated_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gated_capture_pkg
// Purpose  : Shared types and helpers for the gated capture bank.
// Revision : 1.0 - initial release
// ============================================================================
package gated_capture_pkg;

    // Two-state per-channel occupancy
    typedef enum logic {GC_EMPTY, GC_FULL} gc_state_t;

    // Widest counter the helper below can handle
    localparam int c_GC_SAT_MAX_W = 32;

    // Saturating increment of a cnt_w-bit value carried in a 32-bit container
    function automatic logic [31:0] gc_sat_inc(input logic [31:0] cnt, input int cnt_w);
        logic [31:0] lim;
        lim = (cnt_w >= c_GC_SAT_MAX_W) ? '1 : ((32'd1 << cnt_w) - 32'd1);
        return (cnt >= lim) ? lim : (cnt + 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gated_capture_chan.sv
`default_nettype none
// ============================================================================
// Module   : gated_capture_chan
// Purpose  : One capture channel: AND-gated enable, data hold register,
//            EMPTY/FULL handshake FSM and optional saturating overrun counter.
// Config   : GATED_CAPTURE_OVR_CNT_EN builds the overrun counter; otherwise
//            o_ovr_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module gated_capture_chan
    import gated_capture_pkg::*;
#(
    parameter int W     = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_a,
    input  logic             i_b,
    input  logic [W-1:0]     i_x,
    input  logic             i_ready,
    output logic             o_en_q,
    output logic [W-1:0]     o_z_q,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_ovr_cnt
);

    gc_state_t   r_state;
    gc_state_t   w_nxt_state;
    logic        w_en;
    logic        r_en_q;
    logic [W-1:0] r_z_q;

    // Enable is a plain AND of the two terms; never held combinationally
    assign w_en = i_a & i_b;

    // Next-state logic: a simultaneous consume and recapture stays FULL
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            GC_EMPTY: if (w_en)              w_nxt_state = GC_FULL;
            GC_FULL:  if (i_ready && !w_en)  w_nxt_state = GC_EMPTY;
            default:                         w_nxt_state = GC_EMPTY;
        endcase
    end

    // State, sampled enable and held data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= GC_EMPTY;
            r_en_q  <= 1'b0;
            r_z_q   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_en_q  <= w_en;
            if (w_en) begin
                r_z_q <= i_x;
            end
        end
    end

    assign o_en_q  = r_en_q;
    assign o_z_q   = r_z_q;
    assign o_valid = (r_state == GC_FULL);

`ifdef GATED_CAPTURE_OVR_CNT_EN
    logic             w_overrun;
    logic [CNT_W-1:0] r_ovr_cnt;

    // Overrun: new capture lands on unconsumed data (latest data wins)
    assign w_overrun = (r_state == GC_FULL) && !i_ready && w_en;

    // Saturating overrun counter, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr_cnt <= '0;
        end else if (w_overrun) begin
            r_ovr_cnt <= CNT_W'(gc_sat_inc(32'(r_ovr_cnt), CNT_W));
        end
    end

    assign o_ovr_cnt = r_ovr_cnt;
`else
    assign o_ovr_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/gated_capture_bank.sv
`default_nettype none
// ============================================================================
// Module   : gated_capture_bank
// Purpose  : CH independent gated capture channels with valid/ready output.
//            Each channel word is {en_q, z_q}; the top only slices and packs.
// Config   : GATED_CAPTURE_OVR_CNT_EN enables per-channel overrun counters.
// Revision : 1.0 - initial release
// ============================================================================
module gated_capture_bank
    import gated_capture_pkg::*;
#(
    parameter int CH    = 4,
    parameter int W     = 3,
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH-1:0]       a,
    input  logic [CH-1:0]       b,
    input  logic [CH*W-1:0]     x,
    output logic [CH*(W+1)-1:0] res,
    output logic [CH-1:0]       out_valid,
    input  logic [CH-1:0]       out_ready,
    output logic [CH*CNT_W-1:0] ovr_cnt
);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        logic         w_en_q;
        logic [W-1:0] w_z_q;

        gated_capture_chan #(
            .W     (W),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_a       (a[i]),
            .i_b       (b[i]),
            .i_x       (x[i*W +: W]),
            .i_ready   (out_ready[i]),
            .o_en_q    (w_en_q),
            .o_z_q     (w_z_q),
            .o_valid   (out_valid[i]),
            .o_ovr_cnt (ovr_cnt[i*CNT_W +: CNT_W])
        );

        assign res[i*(W+1) +: W+1] = {w_en_q, w_z_q};
    end

endmodule
`default_nettype wire

// File: tb/tb_gated_capture_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_gated_capture_bank
// Purpose  : Scoreboard bench for gated_capture_bank: a reference model
//            predicts each cycle's outputs, which are queued at drive time and
//            compared after the clock edge. Directed scenarios plus random run.
// Config   : honours GATED_CAPTURE_OVR_CNT_EN for expected overrun counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gated_capture_bank;

    localparam int CH    = 4;
    localparam int W     = 3;
    localparam int CNT_W = 4;
`ifdef GATED_CAPTURE_OVR_CNT_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [CH-1:0]       a, b, out_ready;
    logic [CH*W-1:0]     x;
    logic [CH*(W+1)-1:0] res;
    logic [CH-1:0]       out_valid;
    logic [CH*CNT_W-1:0] ovr_cnt;

    gated_capture_bank #(.CH(CH), .W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .x         (x),
        .res       (res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovr_cnt   (ovr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH*(W+1)-1:0] res;
        logic [CH-1:0]       vld;
        logic [CH*CNT_W-1:0] ovr;
    } exp_t;

    exp_t q_exp[$];

    // reference model state
    bit             m_full [CH];
    bit             m_en_q [CH];
    logic [W-1:0]   m_z    [CH];
    int             m_cnt  [CH];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_full[i] = 0; m_en_q[i] = 0; m_z[i] = '0; m_cnt[i] = 0;
        end
    endtask

    // advance model by one edge using current inputs, push expectation
    task automatic model_edge();
        exp_t e;
        bit   en;
        for (int i = 0; i < CH; i++) begin
            en = a[i] & b[i];
            if (m_full[i]) begin
                if (!out_ready[i] && en && OVR_EN && m_cnt[i] < (1 << CNT_W) - 1)
                    m_cnt[i]++;
                if (out_ready[i] && !en) m_full[i] = 0;
            end else if (en) begin
                m_full[i] = 1;
            end
            if (en) m_z[i] = x[i*W +: W];
            m_en_q[i] = en;
        end
        for (int i = 0; i < CH; i++) begin
            e.res[i*(W+1) +: W+1] = {m_en_q[i], m_z[i]};
            e.vld[i]              = m_full[i];
            e.ovr[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        end
        q_exp.push_back(e);
    endtask

    // inputs already driven (at negedge); one edge, then compare
    task automatic cycle();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        if (q_exp.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = q_exp.pop_front();
            chk("res", 64'(res), 64'(e.res));
            chk("out_valid", 64'(out_valid), 64'(e.vld));
            chk("ovr_cnt", 64'(ovr_cnt), 64'(e.ovr));
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [CH-1:0] ia, input logic [CH-1:0] ib,
                         input logic [CH*W-1:0] ix, input logic [CH-1:0] ir);
        a = ia; b = ib; x = ix; out_ready = ir;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive('0, '0, '0, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        a = '0; b = '0; x = '0; out_ready = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_res", 64'(res), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ovr", 64'(ovr_cnt), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // capture on ch0
        drive(4'b0001, 4'b0001, 12'b000_000_000_101, 4'b0000);
        chk("cap_res0", 64'(res[3:0]), 64'b1101);
        chk("cap_vld0", 64'(out_valid[0]), 64'd1);
        drive('0, '0, '0, '0);
        chk("hold_res0", 64'(res[3:0]), 64'b0101);

        // gate: a without b on ch0 (held) and ch3 (empty)
        drive(4'b1001, 4'b0000, 12'b111_111_111_111, 4'b0000);
        chk("gate_res0", 64'(res[3:0]), 64'b0101);
        chk("gate_res3", 64'(res[15:12]), 64'b0000);
        chk("gate_vld3", 64'(out_valid[3]), 64'd0);

        // consume + recapture on ch1
        drive(4'b0010, 4'b0010, 12'b000_000_010_000, 4'b0000);
        drive(4'b0010, 4'b0010, 12'b000_000_110_000, 4'b0010);
        chk("recap_vld1", 64'(out_valid[1]), 64'd1);
        chk("recap_res1", 64'(res[7:4]), 64'b1110);
        chk("recap_ovr1", 64'(ovr_cnt[7:4]), 64'd0);
        drive('0, '0, '0, 4'b0010);
        chk("cons_vld1", 64'(out_valid[1]), 64'd0);

        // overrun saturation on ch2
        for (int k = 0; k < 20; k++)
            drive(4'b0100, 4'b0100, 12'(k % 8) << 6, 4'b0000);
        chk("ovr_sat2", 64'(ovr_cnt[11:8]), OVR_EN ? 64'd15 : 64'd0);
        chk("ovr_data2", 64'(res[10:8]), 64'(19 % 8));

        // reset in the middle of traffic
        for (int k = 0; k < 5; k++)
            drive(4'($urandom), 4'($urandom), 12'($urandom), 4'($urandom));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_res", 64'(res), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ovr", 64'(ovr_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // random independence run; bias enables so overruns do occur
        for (int k = 0; k < 10000; k++)
            drive(4'($urandom) | 4'($urandom), 4'($urandom) | 4'($urandom),
                  12'($urandom), 4'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // absolute time bound
    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
